// File: rtl/shift8_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// shift8_frame_ctrl_if
//   Bundles every non-clock signal of the shift8_frame_ctrl frame sequencer:
//   the upstream sample stream, the port to the 8-entry complex shift
//   register, and the downstream sample stream.
//   Modports:
//     master : the frame controller (drives in_ready, sr_*, out_*, frame_done)
//     slave  : the surrounding environment (upstream source, shift register,
//              downstream sink)
//   Parameter DW: sample width per component (re/im), two's complement.
// ---------------------------------------------------------------------------
interface shift8_frame_ctrl_if #(
    parameter int DW = 10
);
    // upstream stream
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    // shift register port
    logic          sr_ren;
    logic [DW-1:0] sr_dinre;
    logic [DW-1:0] sr_dinim;
    logic [2:0]    sr_sel;
    logic [DW-1:0] sr_doutre;
    logic [DW-1:0] sr_doutim;
    // downstream stream
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic [2:0]    out_idx;
    logic          out_last;
    logic          frame_done;

    modport master (
        input  in_valid, in_re, in_im, sr_doutre, sr_doutim, out_ready,
        output in_ready, sr_ren, sr_dinre, sr_dinim, sr_sel,
               out_valid, out_re, out_im, out_idx, out_last, frame_done
    );

    modport slave (
        output in_valid, in_re, in_im, sr_doutre, sr_doutim, out_ready,
        input  in_ready, sr_ren, sr_dinre, sr_dinim, sr_sel,
               out_valid, out_re, out_im, out_idx, out_last, frame_done
    );
endinterface

// File: rtl/shift8_frame_ctrl.sv
// ---------------------------------------------------------------------------
// shift8_frame_ctrl
//   Frame sequencer in front of the 8-entry complex shift register of the
//   FFT64 datapath. Loads 8 samples from a valid/ready stream into the
//   register, then sweeps the register read select to stream the frame out
//   through a second valid/ready handshake. Load and drain never overlap.
//
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : synchronous active-low reset
//     bus    : shift8_frame_ctrl_if.master
//              in_valid/in_ready/in_re/in_im      upstream samples
//              sr_ren/sr_dinre/sr_dinim/sr_sel    shift register control
//              sr_doutre/sr_doutim                register read data
//              out_valid/out_ready/out_re/out_im  downstream samples
//              out_idx/out_last                   sample index / last flag
//              frame_done                         1-cycle pulse after frame
//
//   Configuration macro SHIFT8_BITREV_EN:
//     defined   -> drain order is bit-reversed (0,4,2,6,1,5,3,7)
//     undefined -> drain order is natural (0..7)
//
//   Only state, cnt and frame_done are flops; the handshake outputs are
//   decoded from them so the first out_valid appears the cycle after the
//   8th accept and the next in_ready the cycle after the 8th drain.
// ---------------------------------------------------------------------------
module shift8_frame_ctrl #(
    parameter int DW = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    shift8_frame_ctrl_if.master bus
);

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state_r;
    logic [2:0]    cnt_r;
    logic          frame_done_r;

    logic          in_ready_s;
    logic          out_valid_s;
    logic          out_last_s;
    logic [2:0]    sel_s;
    logic          accept_s;
    logic          handshake_s;
    logic [DW-1:0] out_re_s;
    logic [DW-1:0] out_im_s;

    // Drain order: the register returns arrival order, so bit-reversal of
    // the drain counter yields the radix-2 DIT input ordering.
    function automatic logic [2:0] map_sel(input logic [2:0] c);
`ifdef SHIFT8_BITREV_EN
        return {c[0], c[1], c[2]};
`else
        return c;
`endif
    endfunction

    // Output decode from state/cnt; everything is held low while in reset.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
        sel_s       = 3'd0;
        if (!rst_n) begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    in_ready_s = 1'b1;
                end
                DRAIN: begin
                    out_valid_s = 1'b1;
                    sel_s       = map_sel(cnt_r);
                    out_last_s  = (cnt_r == 3'd7);
                end
                default: begin
                    in_ready_s  = 1'b0;
                    out_valid_s = 1'b0;
                end
            endcase
        end
    end

    assign accept_s    = bus.in_valid & in_ready_s;
    assign handshake_s = out_valid_s & bus.out_ready;
    assign out_re_s    = bus.sr_doutre;
    assign out_im_s    = bus.sr_doutim;

    // Frame sequencer: counts accepts in LOAD and handshakes in DRAIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= LOAD;
            cnt_r        <= 3'd0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                LOAD: begin
                    if (accept_s) begin
                        cnt_r <= cnt_r + 3'd1;
                        if (cnt_r == 3'd7) begin
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // A stalled downstream simply leaves cnt (and sel) alone.
                    if (handshake_s) begin
                        cnt_r <= cnt_r + 3'd1;
                        if (cnt_r == 3'd7) begin
                            state_r      <= LOAD;
                            frame_done_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= LOAD;
                    cnt_r   <= 3'd0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.sr_ren     = accept_s;
    assign bus.sr_dinre   = bus.in_re;
    assign bus.sr_dinim   = bus.in_im;
    assign bus.sr_sel     = sel_s;
    assign bus.out_valid  = out_valid_s;
    assign bus.out_re     = out_re_s;
    assign bus.out_im     = out_im_s;
    assign bus.out_idx    = sel_s;
    assign bus.out_last   = out_last_s;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_shift8_frame_ctrl.sv
// Self-checking bench for shift8_frame_ctrl. A behavioural 8-entry shift
// register sits on the sr_* port; expected output frames are computed from
// the samples offered upstream and the drain-order rule.
module tb_shift8_frame_ctrl;
    localparam int DW = 10;
`ifdef SHIFT8_BITREV_EN
    localparam bit BITREV = 1'b1;
`else
    localparam bit BITREV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift8_frame_ctrl_if #(.DW(DW)) bus();
    shift8_frame_ctrl #(.DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // behavioural shift register: entry 0 = oldest of the last 8 shifts
    logic [DW-1:0] reg_re [8];
    logic [DW-1:0] reg_im [8];
    always @(posedge clk) begin
        if (bus.sr_ren === 1'b1) begin
            for (int i = 0; i < 7; i++) begin
                reg_re[i] <= reg_re[i+1];
                reg_im[i] <= reg_im[i+1];
            end
            reg_re[7] <= bus.sr_dinre;
            reg_im[7] <= bus.sr_dinim;
        end
    end
    assign bus.sr_doutre = reg_re[bus.sr_sel];
    assign bus.sr_doutim = reg_im[bus.sr_sel];

    int n_cmp = 0;
    int n_fail = 0;

    logic [DW-1:0] src_re [8];
    logic [DW-1:0] src_im [8];
    logic [DW-1:0] cap_re [8];
    logic [DW-1:0] cap_im [8];
    logic [2:0]    cap_idx [8];
    logic          cap_last [8];
    int ren_cnt, load_bad, drain_bad, stall_bad, ir_low_cnt, drain_cycles, first_ov_lat;
    logic [DW-1:0] stall_held_re;
    logic fd_next, fd_next2, ir_next, timeout;

    // drain position k -> frame index, by arithmetic bit reversal
    function automatic int map_idx(input int k);
        return BITREV ? ((k % 2) * 4 + ((k / 2) % 2) * 2 + (k / 4)) : k;
    endfunction

    // offer src samples until n accepts; vmode 0=always,1=every other,2=random
    task automatic load_frame(input int n, input int vmode);
        int acc = 0;
        int cyc = 0;
        logic tog = 1'b1;
        ren_cnt = 0; load_bad = 0; timeout = 1'b0;
        while (acc < n && !timeout) begin
            @(negedge clk);
            case (vmode)
                0:       bus.in_valid = 1'b1;
                1:       begin bus.in_valid = tog; tog = ~tog; end
                default: bus.in_valid = 1'($urandom_range(0, 1));
            endcase
            bus.in_re = src_re[acc];
            bus.in_im = src_im[acc];
            #1;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) load_bad++;
            if (bus.sr_ren !== (bus.in_valid & bus.in_ready)) load_bad++;
            if (bus.sr_ren === 1'b1 && (bus.sr_dinre !== bus.in_re || bus.sr_dinim !== bus.in_im)) load_bad++;
            if (bus.sr_ren === 1'b1) ren_cnt++;
            if (bus.in_valid && bus.in_ready === 1'b1) acc++;
            cyc++;
            if (cyc > 200) timeout = 1'b1;
        end
    endtask

    // collect 8 handshakes; stall out_ready for stall_len cycles at position stall_k
    task automatic drain_frame(input int stall_k, input int stall_len, input bit rmode, input bit hold_valid);
        int k = 0;
        int cyc = 0;
        int st = 0;
        bit stalled;
        drain_bad = 0; stall_bad = 0; ir_low_cnt = 0; drain_cycles = 0; first_ov_lat = -1;
        while (k < 8 && !timeout) begin
            @(negedge clk);
            bus.in_valid = hold_valid;
            bus.in_re = DW'($urandom_range(0, 1023));
            stalled = (k == stall_k && st < stall_len);
            if (stalled) bus.out_ready = 1'b0;
            else if (rmode) bus.out_ready = 1'($urandom_range(0, 1));
            else bus.out_ready = 1'b1;
            #1;
            drain_cycles++;
            if (first_ov_lat < 0 && bus.out_valid === 1'b1) first_ov_lat = cyc;
            if (bus.in_ready === 1'b0) ir_low_cnt++;
            if (bus.sr_ren !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) drain_bad++;
            if (bus.out_idx !== bus.sr_sel) drain_bad++;
            if (stalled) begin
                if (st == 0) stall_held_re = bus.out_re;
                else if (bus.out_re !== stall_held_re || bus.out_idx !== 3'(map_idx(k))) stall_bad++;
                st++;
            end else if (bus.out_ready && bus.out_valid === 1'b1) begin
                cap_re[k] = bus.out_re; cap_im[k] = bus.out_im;
                cap_idx[k] = bus.out_idx; cap_last[k] = bus.out_last;
                k++;
            end
            cyc++;
            if (cyc > 200) timeout = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        #1; fd_next = bus.frame_done; ir_next = bus.in_ready;
        @(negedge clk);
        #1; fd_next2 = bus.frame_done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        bus.in_re = 10'd5; bus.in_im = 10'd6;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({bus.in_ready, bus.sr_ren, bus.out_valid, bus.out_last} !== 4'b0000) begin
                n_fail++; $display("FAIL reset_outputs cyc%0d: got %b expected 0000", c,
                                   {bus.in_ready, bus.sr_ren, bus.out_valid, bus.out_last});
            end
        end
        n_cmp++;
        if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
        @(negedge clk); rst_n = 1'b1; bus.in_valid = 1'b0; #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin src_re[i] = DW'(i); src_im[i] = '0; end
        load_frame(8, 0);
        drain_frame(-1, 0, 1'b0, 1'b0);
        n_cmp++;
        if (ren_cnt !== 8 || load_bad !== 0 || drain_bad !== 0 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL stream_ctrl: ren=%0d load_bad=%0d drain_bad=%0d to=%b expected 8/0/0/0", ren_cnt, load_bad, drain_bad, timeout);
        end
        n_cmp++;
        if (first_ov_lat !== 0) begin n_fail++; $display("FAIL stream_latency: got %0d expected 0", first_ov_lat); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (cap_re[k] !== src_re[map_idx(k)] || cap_im[k] !== src_im[map_idx(k)] ||
                cap_idx[k] !== 3'(map_idx(k)) || cap_last[k] !== (k == 7)) begin
                n_fail++; $display("FAIL stream_out k%0d: re=%0d idx=%0d last=%b expected %0d/%0d/%b",
                                   k, cap_re[k], cap_idx[k], cap_last[k], src_re[map_idx(k)], map_idx(k), (k == 7));
            end
        end
        n_cmp++;
        if ({fd_next, fd_next2, ir_next} !== 3'b101) begin
            n_fail++; $display("FAIL stream_frame_done: fd=%b fd+1=%b in_ready=%b expected 1/0/1", fd_next, fd_next2, ir_next);
        end
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 8; i++) begin src_re[i] = DW'($urandom_range(0, 1023)); src_im[i] = DW'($urandom_range(0, 1023)); end
        load_frame(8, 1);
        drain_frame(-1, 0, 1'b0, 1'b0);
        n_cmp++;
        if (ren_cnt !== 8 || load_bad !== 0 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL gapped_shifts: ren=%0d load_bad=%0d to=%b expected 8/0/0", ren_cnt, load_bad, timeout);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (cap_re[k] !== src_re[map_idx(k)] || cap_im[k] !== src_im[map_idx(k)]) begin
                n_fail++; $display("FAIL gapped_out k%0d: got %0d/%0d expected %0d/%0d", k, cap_re[k], cap_im[k], src_re[map_idx(k)], src_im[map_idx(k)]);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 8; i++) begin src_re[i] = DW'(i); src_im[i] = DW'(100 + i); end
        load_frame(8, 0);
        drain_frame(3, 3, 1'b0, 1'b0);
        n_cmp++;
        if (stall_held_re !== src_re[map_idx(3)] || stall_bad !== 0 || drain_bad !== 0) begin
            n_fail++; $display("FAIL stall_hold: held=%0d bad=%0d drain_bad=%0d expected %0d/0/0", stall_held_re, stall_bad, drain_bad, src_re[map_idx(3)]);
        end
        n_cmp++;
        if (cap_idx[4] !== 3'(map_idx(4)) || cap_re[4] !== src_re[map_idx(4)] || drain_cycles !== 11) begin
            n_fail++; $display("FAIL stall_release: idx=%0d re=%0d cycles=%0d expected %0d/%0d/11", cap_idx[4], cap_re[4], drain_cycles, map_idx(4), src_re[map_idx(4)]);
        end
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 8; i++) begin src_re[i] = DW'(500 + i); src_im[i] = DW'(600 + i); end
        load_frame(5, 0);
        @(negedge clk); rst_n = 1'b0; bus.in_valid = 1'b1; #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.sr_ren !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs: in_ready=%b sr_ren=%b out_valid=%b expected 0/0/0", bus.in_ready, bus.sr_ren, bus.out_valid);
        end
        @(negedge clk); rst_n = 1'b1; bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin src_re[i] = DW'(10 + i); src_im[i] = DW'(20 + i); end
        load_frame(8, 0);
        n_cmp++;
        if (ren_cnt !== 8 || load_bad !== 0) begin n_fail++; $display("FAIL midreset_reload: ren=%0d bad=%0d expected 8/0", ren_cnt, load_bad); end
        drain_frame(-1, 0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (cap_re[k] !== DW'(10 + map_idx(k)) || cap_im[k] !== DW'(20 + map_idx(k))) begin
                n_fail++; $display("FAIL midreset_out k%0d: got %0d expected %0d", k, cap_re[k], 10 + map_idx(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) begin
                src_re[i] = (f == 0) ? DW'(i) : DW'(-(i + 1));
                src_im[i] = DW'(f * 8 + i);
            end
            load_frame(8, 0);
            drain_frame(-1, 0, 1'b0, 1'b1);
            n_cmp++;
            if (ir_low_cnt !== 8 || drain_cycles !== 8 || drain_bad !== 0 || ir_next !== 1'b1) begin
                n_fail++; $display("FAIL b2b_drain f%0d: in_ready_low=%0d cycles=%0d bad=%0d ir_next=%b expected 8/8/0/1", f, ir_low_cnt, drain_cycles, drain_bad, ir_next);
            end
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if (cap_re[k] !== src_re[map_idx(k)] || cap_last[k] !== (k == 7)) begin
                    n_fail++; $display("FAIL b2b_out f%0d k%0d: got %0d last=%b expected %0d", f, k, cap_re[k], cap_last[k], src_re[map_idx(k)]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 8; i++) begin src_re[i] = DW'($urandom_range(0, 1023)); src_im[i] = DW'($urandom_range(0, 1023)); end
            load_frame(8, 2);
            drain_frame(-1, 0, 1'b1, 1'b1);
            n_cmp++;
            if (ren_cnt !== 8 || load_bad !== 0 || drain_bad !== 0 || timeout !== 1'b0 || fd_next !== 1'b1) begin
                n_fail++; $display("FAIL random_ctrl f%0d: ren=%0d lbad=%0d dbad=%0d to=%b fd=%b", f, ren_cnt, load_bad, drain_bad, timeout, fd_next);
            end
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if (cap_re[k] !== src_re[map_idx(k)] || cap_im[k] !== src_im[map_idx(k)] || cap_idx[k] !== 3'(map_idx(k))) begin
                    n_fail++; $display("FAIL random_out f%0d k%0d: got %0d/%0d idx %0d expected %0d/%0d idx %0d", f, k,
                                       cap_re[k], cap_im[k], cap_idx[k], src_re[map_idx(k)], src_im[map_idx(k)], map_idx(k));
                end
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_re = '0; bus.in_im = '0; bus.out_ready = 1'b1;
        test_reset();
        test_stream();
        test_gapped();
        test_stall();
        test_midreset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
